// File: rtl/rs_pkg.sv
// rs_pkg: shared types for the multi-issue reservation station.
// Holds ID_EX_PACKET, RS_ENTRY_T, tag/data widths and popcount.
package rs_pkg;

  localparam int PRF   = 64;
  localparam int TAG_W = $clog2(PRF);
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [3:0]       alu_func;
    logic [TAG_W-1:0] dest_tag;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
  } ID_EX_PACKET;

  typedef struct packed {
    logic        valid;
    logic        rs1_rdy;
    logic        rs2_rdy;
    ID_EX_PACKET pkt;
  } RS_ENTRY_T;

  function automatic int unsigned popcount(
    input logic [63:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++)
      n = n + {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/rs_multi_issue_if.sv
// rs_multi_issue_if: dispatch, CDB, issue and occupancy bus of the RS.
// master = dispatch/CDB/FU side, slave = reservation station.
interface rs_multi_issue_if #(
  parameter int WAYS    = 2,
  parameter int CDB_N   = 2,
  parameter int ISSUE_N = 2,
  parameter int DEPTH   = 16
);
  import rs_pkg::*;

  localparam int AW = $clog2(WAYS + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic                          squash;
  logic [WAYS-1:0]               disp_valid;
  ID_EX_PACKET [WAYS-1:0]        disp_packet;
  logic [WAYS-1:0]               disp_rs1_rdy;
  logic [WAYS-1:0]               disp_rs2_rdy;
  logic [AW-1:0]                 disp_accept_cnt;
  logic [CDB_N-1:0]              cdb_valid;
  logic [CDB_N-1:0][TAG_W-1:0]   cdb_tag;
  logic [CDB_N-1:0][XLEN-1:0]    cdb_data;
  logic [ISSUE_N-1:0]            fu_busy;
  logic [ISSUE_N-1:0]            issue_valid;
  ID_EX_PACKET [ISSUE_N-1:0]     issue_packet;
  logic [CW-1:0]                 free_count;
  logic [CW-1:0]                 free_count_next;

  modport master (
    output squash, disp_valid, disp_packet,
    output disp_rs1_rdy, disp_rs2_rdy,
    output cdb_valid, cdb_tag, cdb_data, fu_busy,
    input  disp_accept_cnt, issue_valid,
    input  issue_packet, free_count, free_count_next
  );

  modport slave (
    input  squash, disp_valid, disp_packet,
    input  disp_rs1_rdy, disp_rs2_rdy,
    input  cdb_valid, cdb_tag, cdb_data, fu_busy,
    output disp_accept_cnt, issue_valid,
    output issue_packet, free_count, free_count_next
  );

endinterface

// File: rtl/rs_slot.sv
// rs_slot: one RS entry; load with dispatch bypass, CDB wakeup, clear.
// Ports: clock, reset, clear, load, load_entry, cdb_*, entry (registered).
module rs_slot
  import rs_pkg::*;
#(
  parameter int CDB_N = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        load,
  input  RS_ENTRY_T                   load_entry,
  input  logic [CDB_N-1:0]            cdb_valid,
  input  logic [CDB_N-1:0][TAG_W-1:0] cdb_tag,
  input  logic [CDB_N-1:0][XLEN-1:0]  cdb_data,
  output RS_ENTRY_T                   entry
);

  RS_ENTRY_T       base;
  RS_ENTRY_T       nxt;
  logic            hit1;
  logic            hit2;
  logic [XLEN-1:0] d1;
  logic [XLEN-1:0] d2;

  // Snooping the incoming packet as well as the stored one gives
  // dispatch bypass for free. Descending scan: lowest port wins.
  always_comb begin
    base = load ? load_entry : entry;
    hit1 = 1'b0;
    hit2 = 1'b0;
    d1   = '0;
    d2   = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (cdb_valid[c] &&
          cdb_tag[c] == base.pkt.rs1_value[TAG_W-1:0]) begin
        hit1 = 1'b1;
        d1   = cdb_data[c];
      end
      if (cdb_valid[c] &&
          cdb_tag[c] == base.pkt.rs2_value[TAG_W-1:0]) begin
        hit2 = 1'b1;
        d2   = cdb_data[c];
      end
    end
    nxt = base;
    if (base.valid && !base.rs1_rdy && hit1) begin
      nxt.rs1_rdy       = 1'b1;
      nxt.pkt.rs1_value = d1;
    end
    if (base.valid && !base.rs2_rdy && hit2) begin
      nxt.rs2_rdy       = 1'b1;
      nxt.pkt.rs2_value = d2;
    end
    // Issuing or squashed entry leaves; late wakeup is dropped.
    if (clear)
      nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (reset)
      entry <= '0;
    else
      entry <= nxt;
  end

endmodule

// File: rtl/rs_multi_issue.sv
// rs_multi_issue: parametrised RS, WAYS dispatch, CDB_N wakeup, ISSUE_N issue.
// Ports: clock, reset, bus (slave). RS_AGE_ORDER_EN selects oldest-first issue.
module rs_multi_issue
  import rs_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int WAYS    = 2,
  parameter int CDB_N   = 2,
  parameter int ISSUE_N = 2
) (
  input  logic            clock,
  input  logic            reset,
  rs_multi_issue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(WAYS + 1);

  RS_ENTRY_T        ent        [DEPTH];
  RS_ENTRY_T        load_entry [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [DEPTH-1:0] elig;
  logic [CW-1:0]    free_count;
  logic [CW-1:0]    n_issue;
  logic [CW:0]      fc_wide;
  logic [AW-1:0]    n_req;
  logic [AW-1:0]    acc;
  logic             kill;

  assign kill = reset | bus.squash;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_slot #(
      .CDB_N (CDB_N)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear[i]),
      .load       (load[i]),
      .load_entry (load_entry[i]),
      .cdb_valid  (bus.cdb_valid),
      .cdb_tag    (bus.cdb_tag),
      .cdb_data   (bus.cdb_data),
      .entry      (ent[i])
    );
    assign elig[i] = ent[i].valid
                   & ent[i].rs1_rdy
                   & ent[i].rs2_rdy;
  end

  // Allocation: accepted lanes fill free slots lowest index first.
  always_comb begin : p_alloc
    int k;
    n_req = AW'(popcount(64'(bus.disp_valid)));
    if (int'(n_req) < int'(free_count))
      acc = n_req;
    else
      acc = AW'(free_count);
    if (kill)
      acc = '0;
    load = '0;
    k    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      load_entry[i] = '0;
      if (!ent[i].valid && k < int'(acc)) begin
        load[i] = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (w == k) begin
            load_entry[i].valid   = 1'b1;
            load_entry[i].rs1_rdy = bus.disp_rs1_rdy[w];
            load_entry[i].rs2_rdy = bus.disp_rs2_rdy[w];
            load_entry[i].pkt     = bus.disp_packet[w];
          end
        end
        k = k + 1;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // older[i][j]: entry i was dispatched before entry j.
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [DEPTH-1:0][DEPTH-1:0] older_nxt;

  // Ascending slot order matches lane order, so lower
  // same-cycle loads are marked older than higher ones.
  always_comb begin
    older_nxt = older;
    for (int s = 0; s < DEPTH; s++) begin
      if (load[s]) begin
        for (int j = 0; j < DEPTH; j++)
          older_nxt[s][j] = 1'b0;
        for (int j = 0; j < DEPTH; j++)
          older_nxt[j][s] = ent[j].valid
                          | (load[j] & (j < s));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      older <= '0;
    else
      older <= older_nxt;
  end
`endif

  // Issue select: each free lane takes the next candidate.
  always_comb begin : p_issue
    logic [DEPTH-1:0] cand;
    logic             found;
    logic             ok;
    cand    = elig;
    found   = 1'b0;
    ok      = 1'b0;
    clear   = {DEPTH{bus.squash}};
    n_issue = '0;
    for (int l = 0; l < ISSUE_N; l++) begin
      bus.issue_valid[l]  = 1'b0;
      bus.issue_packet[l] = '0;
    end
    for (int l = 0; l < ISSUE_N; l++) begin
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ok = cand[i] & ~found & ~bus.fu_busy[l] & ~kill;
`ifdef RS_AGE_ORDER_EN
        for (int j = 0; j < DEPTH; j++)
          if (j != i && cand[j] && older[j][i])
            ok = 1'b0;
`endif
        if (ok) begin
          found               = 1'b1;
          cand[i]             = 1'b0;
          clear[i]            = 1'b1;
          bus.issue_valid[l]  = 1'b1;
          bus.issue_packet[l] = ent[i].pkt;
          n_issue             = n_issue + CW'(1);
        end
      end
    end
  end

  always_comb begin
    fc_wide = {1'b0, free_count}
            + (CW+1)'(n_issue)
            - (CW+1)'(acc);
    if (kill)
      bus.free_count_next = CW'(DEPTH);
    else
      bus.free_count_next = fc_wide[CW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_count <= CW'(DEPTH);
    end else begin
      assert (bus.squash || fc_wide <= (CW+1)'(DEPTH));
      free_count <= bus.free_count_next;
    end
  end

  assign bus.free_count      = free_count;
  assign bus.disp_accept_cnt = acc;

endmodule

// File: tb/tb_rs_multi_issue.sv
// tb_rs_multi_issue: vector table plus hand sequences for rs_multi_issue.
// Issued packets are matched against a scoreboard of expected packets.
module tb_rs_multi_issue;
  import rs_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rs_multi_issue_if bus ();

  rs_multi_issue dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          model_fc = 16;
  logic [31:0] pc_n     = 32'h100;
  logic [31:0] last_pc0;
  ID_EX_PACKET sb [$];
  ID_EX_PACKET p;
  ID_EX_PACKET e;
  ID_EX_PACKET pa;
  ID_EX_PACKET pb;

  typedef struct {
    int         n;
    logic [1:0] busy;
    int         acc;
    logic [1:0] iv;
    int         fn;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input ID_EX_PACKET a);
    int idx;
    idx = -1;
    foreach (sb[i])
      if (idx < 0 && sb[i].pc == a.pc)
        idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL sb_unexpected act_pc=0x%0h exp=none", a.pc);
    end else begin
      checks++;
      if (sb[idx] !== a) begin
        errors++;
        $display("FAIL sb_data pc=0x%0h act=%h exp=%h",
                 a.pc, a, sb[idx]);
      end
      sb.delete(idx);
    end
  endtask

  function automatic ID_EX_PACKET mk(input logic [31:0] pc,
                                     input logic [31:0] v1,
                                     input logic [31:0] v2);
    ID_EX_PACKET r;
    r.pc        = pc;
    r.alu_func  = pc[5:2];
    r.dest_tag  = pc[TAG_W+1:2];
    r.rs1_value = v1;
    r.rs2_value = v2;
    return r;
  endfunction

  task automatic idle();
    bus.squash       = 1'b0;
    bus.disp_valid   = '0;
    bus.disp_packet  = '0;
    bus.disp_rs1_rdy = '0;
    bus.disp_rs2_rdy = '0;
    bus.cdb_valid    = '0;
    bus.cdb_tag      = '0;
    bus.cdb_data     = '0;
    bus.fu_busy      = '0;
  endtask

  task automatic disp(input int lane, input ID_EX_PACKET d,
                      input logic r1, input logic r2);
    bus.disp_valid[lane]   = 1'b1;
    bus.disp_packet[lane]  = d;
    bus.disp_rs1_rdy[lane] = r1;
    bus.disp_rs2_rdy[lane] = r2;
  endtask

  task automatic tick(input string nm, input int exp_acc,
                      input logic [1:0] exp_iv, input int exp_fn);
    @(negedge clock);
    chk({nm, ".acc"}, int'(bus.disp_accept_cnt), exp_acc);
    chk({nm, ".iv"}, int'(bus.issue_valid), int'(exp_iv));
    chk({nm, ".fc"}, int'(bus.free_count), model_fc);
    chk({nm, ".fcn"}, int'(bus.free_count_next), exp_fn);
    last_pc0 = bus.issue_packet[0].pc;
    for (int l = 0; l < 2; l++)
      if (bus.issue_valid[l])
        sb_check(bus.issue_packet[l]);
    @(posedge clock);
    #1;
    model_fc = exp_fn;
  endtask

  task automatic ready_op(input int lane, input logic push);
    p = mk(pc_n, pc_n ^ 32'h1111, pc_n ^ 32'h2222);
    disp(lane, p, 1'b1, 1'b1);
    if (push)
      sb.push_back(p);
    pc_n += 4;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    ready_op(0, 1'b0);
    ready_op(1, 1'b0);
    tick("reset", 0, 2'b00, 16);
    reset = 1'b0;

    vt[0] = '{2, 2'b00, 2, 2'b00, 14};
    vt[1] = '{0, 2'b00, 0, 2'b11, 16};
    vt[2] = '{2, 2'b00, 2, 2'b00, 14};
    vt[3] = '{0, 2'b01, 0, 2'b10, 15};
    vt[4] = '{0, 2'b00, 0, 2'b01, 16};
    vt[5] = '{1, 2'b11, 1, 2'b00, 15};
    vt[6] = '{2, 2'b11, 2, 2'b00, 13};
    vt[7] = '{0, 2'b10, 0, 2'b01, 14};
    vt[8] = '{0, 2'b00, 0, 2'b11, 16};
    vt[9] = '{0, 2'b00, 0, 2'b00, 16};
    for (int r = 0; r < 10; r++) begin
      idle();
      bus.fu_busy = vt[r].busy;
      for (int k = 0; k < vt[r].n; k++)
        ready_op(k, k < vt[r].acc);
      tick($sformatf("vec%0d", r), vt[r].acc,
           vt[r].iv, vt[r].fn);
    end

    // dispatch bypass on both operands
    idle();
    p = mk(pc_n, 32'd5, 32'd6);
    disp(0, p, 1'b0, 1'b0);
    bus.cdb_valid   = 2'b11;
    bus.cdb_tag[0]  = 6'd6;
    bus.cdb_data[0] = 32'h66;
    bus.cdb_tag[1]  = 6'd5;
    bus.cdb_data[1] = 32'hDEAD;
    e = p;
    e.rs1_value = 32'hDEAD;
    e.rs2_value = 32'h66;
    sb.push_back(e);
    pc_n += 4;
    tick("byp", 1, 2'b00, 15);
    idle();
    tick("byp_iss", 0, 2'b01, 16);

    // duplicate tag: port 0 wins
    idle();
    p = mk(pc_n, 32'd9, 32'h1234);
    disp(0, p, 1'b0, 1'b1);
    bus.cdb_valid   = 2'b11;
    bus.cdb_tag[0]  = 6'd9;
    bus.cdb_data[0] = 32'hAAAA;
    bus.cdb_tag[1]  = 6'd9;
    bus.cdb_data[1] = 32'hBBBB;
    e = p;
    e.rs1_value = 32'hAAAA;
    sb.push_back(e);
    pc_n += 4;
    tick("dup", 1, 2'b00, 15);
    idle();
    tick("dup_iss", 0, 2'b01, 16);

    // fill with waiting ops, overflow, wake, drain
    for (int c = 0; c < 8; c++) begin
      idle();
      for (int k = 0; k < 2; k++) begin
        if (k == 0)
          p = mk(pc_n, 32'd7, 32'd8);
        else
          p = mk(pc_n, 32'd7, pc_n);
        disp(k, p, 1'b0, k == 1);
        e = p;
        e.rs1_value = 32'h77;
        if (k == 0)
          e.rs2_value = 32'h88;
        sb.push_back(e);
        pc_n += 4;
      end
      tick($sformatf("fill%0d", c), 2, 2'b00, 14 - 2 * c);
    end
    idle();
    ready_op(0, 1'b0);
    ready_op(1, 1'b0);
    tick("full", 0, 2'b00, 0);
    idle();
    bus.cdb_valid   = 2'b11;
    bus.cdb_tag[0]  = 6'd7;
    bus.cdb_data[0] = 32'h77;
    bus.cdb_tag[1]  = 6'd8;
    bus.cdb_data[1] = 32'h88;
    tick("wake", 0, 2'b00, 0);
    idle();
    for (int c = 0; c < 8; c++)
      tick($sformatf("drain%0d", c), 0, 2'b11, 2 * c + 2);

    // squash with dispatch and ready entries
    for (int c = 0; c < 4; c++) begin
      idle();
      bus.fu_busy = 2'b11;
      ready_op(0, 1'b1);
      ready_op(1, 1'b1);
      tick($sformatf("sqf%0d", c), 2, 2'b00, 14 - 2 * c);
    end
    idle();
    ready_op(0, 1'b0);
    ready_op(1, 1'b0);
    bus.squash = 1'b1;
    tick("squash", 0, 2'b00, 16);
    sb.delete();
    idle();
    tick("post_sq", 0, 2'b00, 16);

    // A lands in slot 3, B later in slot 0
    idle();
    bus.fu_busy = 2'b11;
    ready_op(0, 1'b1);
    ready_op(1, 1'b1);
    tick("age_a", 2, 2'b00, 14);
    idle();
    bus.fu_busy = 2'b11;
    ready_op(0, 1'b1);
    pa = mk(pc_n, 32'd30, 32'd5);
    disp(1, pa, 1'b0, 1'b1);
    e = pa;
    e.rs1_value = 32'hA0A0;
    sb.push_back(e);
    pc_n += 4;
    tick("age_b", 2, 2'b00, 12);
    idle();
    tick("age_c", 0, 2'b11, 14);
    tick("age_d", 0, 2'b01, 15);
    idle();
    bus.fu_busy = 2'b11;
    pb = mk(pc_n, pc_n ^ 32'h1111, pc_n ^ 32'h2222);
    disp(0, pb, 1'b1, 1'b1);
    sb.push_back(pb);
    pc_n += 4;
    bus.cdb_valid[0] = 1'b1;
    bus.cdb_tag[0]   = 6'd30;
    bus.cdb_data[0]  = 32'hA0A0;
    tick("age_e", 1, 2'b00, 14);
    idle();
    bus.fu_busy = 2'b10;
    tick("age_f", 0, 2'b01, 15);
`ifdef RS_AGE_ORDER_EN
    chk("age_pick", int'(last_pc0), int'(pa.pc));
`else
    chk("age_pick", int'(last_pc0), int'(pb.pc));
`endif
    idle();
    tick("age_g", 0, 2'b01, 16);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
